// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_pkg                                                   |
// | Description : Shared constants, types and helpers for reg_file_mp.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int CNTW_DEF  = $clog2(NREGS_DEF + 1);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] data_t;

    // Width needed to hold a count of 0..n busy registers.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_mp_if                                                |
// | Description : Read/write/issue bus of the multi-port register file.         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface reg_file_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = cnt_width(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic [CW-1:0]       sb_cnt;

    modport master (
        output rd_addr, we, wa, wd, iss_valid, iss_addr,
        input  rd_data, rd_busy, sb_cnt
    );

    modport slave (
        input  rd_addr, we, wa, wd, iss_valid, iss_addr,
        output rd_data, rd_busy, sb_cnt
    );

endinterface
`default_nettype wire

// File: rtl/reg_file_mp_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rf_scoreboard                                                 |
// | Description : Per-register busy bits and running busy count.                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = cnt_width(NREGS)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             we,
    input  wire logic [AW-1:0]    wa,
    input  wire logic             iss_valid,
    input  wire logic [AW-1:0]    iss_addr,
    output logic      [NREGS-1:0] busy,
    output logic      [CW-1:0]    sb_cnt
);

    logic [NREGS-1:0] busy_d, busy_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             w_set, w_clr;

    // Issue is applied after write so a same-cycle producer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (we)        busy_d[wa]       = 1'b0;
        if (iss_valid) busy_d[iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        w_set = iss_valid && (iss_addr != '0) && !busy_q[iss_addr];
        w_clr = we && (wa != '0) && busy_q[wa] && !(iss_valid && (iss_addr == wa));
        cnt_d = cnt_q + CW'(w_set) - CW'(w_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy   = busy_q;
    assign sb_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_mp                                                   |
// | Description : NRD-read / 1-write register file with pending-write           |
// |               scoreboard; REGFILE_BYPASS_EN enables write-to-read bypass.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) (
    input wire logic      clk,
    input wire logic      rst,
    reg_file_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = cnt_width(NREGS);

    logic [XLEN-1:0]  regs_d [NREGS];
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] w_busy;

    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.wa != '0)) regs_d[bus.wa] = bus.wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (bus.we),
        .wa        (bus.wa),
        .iss_valid (bus.iss_valid),
        .iss_addr  (bus.iss_addr),
        .busy      (w_busy),
        .sb_cnt    (bus.sb_cnt)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;

        assign w_addr = bus.rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign w_hit = bus.we && (bus.wa != '0) && (w_addr == bus.wa);
`else
        assign w_hit = 1'b0;
`endif
        assign bus.rd_data[i*XLEN +: XLEN] = w_hit           ? bus.wd :
                                             (w_addr == '0)  ? '0     : regs_q[w_addr];
        assign bus.rd_busy[i]              = w_hit ? 1'b0 : w_busy[w_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_file_mp                                                |
// | Description : Directed self-checking bench for reg_file_mp (NRD=2).         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we        = 1'b0;
        bus.wa        = '0;
        bus.wd        = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
        #1;
    endtask

    task automatic do_wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        bus.we = 1'b1; bus.wa = a; bus.wd = d;
        tick();
        idle();
    endtask

    task automatic do_iss(input logic [4:0] a);
        idle();
        bus.iss_valid = 1'b1; bus.iss_addr = a;
        tick();
        idle();
    endtask

    initial begin
        idle();
        bus.rd_addr = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        set_rd(5'd5, 5'd10);
        check_eq("rst_rd0",  bus.rd_data[31:0],  64'h0);
        check_eq("rst_rd1",  bus.rd_data[63:32], 64'h0);
        check_eq("rst_busy", bus.rd_busy,        64'h0);
        check_eq("rst_cnt",  bus.sb_cnt,         64'h0);

        // Preload, then reset overriding a concurrent write and issue
        do_wr(5'd5,  32'h1111_1111);
        do_wr(5'd10, 32'h2222_2222);
        do_iss(5'd10);
        set_rd(5'd5, 5'd10);
        check_eq("pre_rd0",   bus.rd_data[31:0],  64'h1111_1111);
        check_eq("pre_rd1",   bus.rd_data[63:32], 64'h2222_2222);
        check_eq("pre_busy",  bus.rd_busy,        64'h2);
        check_eq("pre_cnt",   bus.sb_cnt,         64'h1);
        rst = 1'b1;
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEAD_BEEF;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd12;
        tick();
        rst = 1'b0;
        idle();
        set_rd(5'd5, 5'd10);
        check_eq("rst2_rd0",  bus.rd_data[31:0],  64'h0);
        check_eq("rst2_rd1",  bus.rd_data[63:32], 64'h0);
        check_eq("rst2_busy", bus.rd_busy,        64'h0);
        check_eq("rst2_cnt",  bus.sb_cnt,         64'h0);

        // Register 0 write and issue are ignored
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFF_FFFF;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        check_eq("r0_rd0",  bus.rd_data[31:0],  64'h0);
        check_eq("r0_rd1",  bus.rd_data[63:32], 64'h0);
        check_eq("r0_busy", bus.rd_busy,        64'h0);
        check_eq("r0_cnt",  bus.sb_cnt,         64'h0);

        // Scoreboard counting: issue 3, 7, 3 again
        do_iss(5'd3);
        check_eq("sb_cnt_a", bus.sb_cnt, 64'd1);
        do_iss(5'd7);
        check_eq("sb_cnt_b", bus.sb_cnt, 64'd2);
        do_iss(5'd3);
        check_eq("sb_cnt_c", bus.sb_cnt, 64'd2);
        set_rd(5'd3, 5'd7);
        check_eq("sb_busy_37", bus.rd_busy, 64'h3);
        do_wr(5'd3, 32'h0000_0033);
        set_rd(5'd3, 5'd7);
        check_eq("wb_cnt",  bus.sb_cnt,        64'd1);
        check_eq("wb_busy", bus.rd_busy,       64'h2);
        check_eq("wb_data", bus.rd_data[31:0], 64'h33);
        do_wr(5'd9, 32'h0000_0099);
        set_rd(5'd9, 5'd7);
        check_eq("nb_cnt",  bus.sb_cnt,        64'd1);
        check_eq("nb_busy", bus.rd_busy,       64'h2);
        check_eq("nb_data", bus.rd_data[31:0], 64'h99);

        // Same-cycle issue and write to reg 4: issue wins
        do_iss(5'd4);
        check_eq("iw_cnt0", bus.sb_cnt, 64'd2);
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h0000_1234;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
        tick();
        idle();
        set_rd(5'd4, 5'd4);
        check_eq("iw_data", bus.rd_data[31:0], 64'h1234);
        check_eq("iw_busy", bus.rd_busy,       64'h3);
        check_eq("iw_cnt",  bus.sb_cnt,        64'd2);

        // Bypass on reg 6 (busy, old value 0x66)
        do_wr(5'd6, 32'h0000_0066);
        do_iss(5'd6);
        check_eq("bp_cnt0", bus.sb_cnt, 64'd3);
        bus.rd_addr = {5'd6, 5'd6};
        bus.we = 1'b1; bus.wa = 5'd6; bus.wd = 32'hA5A5_0001;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("bp_rd0",  bus.rd_data[31:0],  64'hA5A5_0001);
        check_eq("bp_rd1",  bus.rd_data[63:32], 64'hA5A5_0001);
        check_eq("bp_busy", bus.rd_busy,        64'h0);
`else
        check_eq("bp_rd0",  bus.rd_data[31:0],  64'h66);
        check_eq("bp_rd1",  bus.rd_data[63:32], 64'h66);
        check_eq("bp_busy", bus.rd_busy,        64'h3);
`endif
        tick();
        idle();
        #1;
        check_eq("bp_nx_rd0",  bus.rd_data[31:0],  64'hA5A5_0001);
        check_eq("bp_nx_rd1",  bus.rd_data[63:32], 64'hA5A5_0001);
        check_eq("bp_nx_busy", bus.rd_busy,        64'h0);
        check_eq("bp_nx_cnt",  bus.sb_cnt,         64'd2);

        // Concurrent set of 8 and clear of 2
        do_iss(5'd2);
        check_eq("sc_cnt0", bus.sb_cnt, 64'd3);
        bus.we = 1'b1; bus.wa = 5'd2; bus.wd = 32'h0000_0022;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd8;
        tick();
        idle();
        set_rd(5'd2, 5'd8);
        check_eq("sc_cnt",  bus.sb_cnt,        64'd3);
        check_eq("sc_busy", bus.rd_busy,       64'h2);
        check_eq("sc_data", bus.rd_data[31:0], 64'h22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
